// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch FSM states and the IF/ID pipeline record.
package cpu_types_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_PEND = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
  } ifid_t;
endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, talks to the I-cache and fills the IF/ID latch.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  stall,
  input  logic  flush,
  input  logic  redirect_en,
  input  word_t redirect_pc,
  input  logic  halt,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc
);

  fetch_state_t r_state, w_state_nx;
  word_t        r_pc, w_pc_nx;
  word_t        r_pend, w_pend_nx;
  ifid_t        r_ifid, w_ifid_nx;
  word_t        w_redir_pc;
  word_t        w_pc_plus4;

  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
  assign w_pc_plus4 = r_pc + 32'd4;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_pc    <= PC_INIT;
      r_pend  <= '0;
      r_ifid  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_pend  <= w_pend_nx;
      r_ifid  <= w_ifid_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_pend_nx  = r_pend;
    w_ifid_nx  = r_ifid;
    unique case (r_state)
      FETCH: begin
        if (halt) begin
          w_state_nx      = HALTED;
          w_ifid_nx.valid = 1'b0;
        end else if (redirect_en) begin
          // The in-flight fetch is wrong-path; a miss must finish at the old address first.
          w_ifid_nx.valid = 1'b0;
          if (ihit) begin
            w_pc_nx = w_redir_pc;
          end else begin
            w_pend_nx  = w_redir_pc;
            w_state_nx = REDIR_PEND;
          end
        end else if (ihit && !stall) begin
          w_pc_nx = w_pc_plus4;
          if (flush) begin
            w_ifid_nx.valid = 1'b0;
          end else begin
            w_ifid_nx.valid = 1'b1;
            w_ifid_nx.instr = imemload;
            w_ifid_nx.pc    = r_pc;
            w_ifid_nx.npc   = w_pc_plus4;
          end
        end else if (flush) begin
          w_ifid_nx.valid = 1'b0;
        end
      end
      REDIR_PEND: begin
        w_ifid_nx.valid = 1'b0;
        if (halt) begin
          w_state_nx = HALTED;
        end else begin
          if (redirect_en) w_pend_nx = w_redir_pc;
          if (ihit) begin
            w_pc_nx    = redirect_en ? w_redir_pc : r_pend;
            w_state_nx = FETCH;
          end
        end
      end
      HALTED: begin
        w_ifid_nx.valid = 1'b0;
      end
      default: begin
        w_state_nx = FETCH;
      end
    endcase
  end

  assign imemREN    = (r_state != HALTED);
  assign imemaddr   = r_pc;
  assign ifid_valid = r_ifid.valid;
  assign ifid_instr = r_ifid.instr;
  assign ifid_pc    = r_ifid.pc;
  assign ifid_npc   = r_ifid.npc;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter: PC_INIT, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port: CLK  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: ihit  input  1  instruction cache: fetch at imemaddr complete this cycle.
REQ-005 SHALL have port: imemload  input  32  instruction word, valid when ihit=1.
REQ-006 SHALL have port: imemREN  output  1  instruction read request to instruction cache.
REQ-007 SHALL have port: imemaddr  output  32  word address of the current fetch (equals PC).
REQ-008 SHALL have port: stall  input  1  hazard unit: decode cannot accept; hold PC and IF/ID.
REQ-009 SHALL have port: flush  input  1  squash IF/ID contents.
REQ-010 SHALL have port: redirect_en  input  1  branch/jump resolved taken; change fetch stream.
REQ-011 SHALL have port: redirect_pc  input  32  new fetch target.
REQ-012 SHALL have port: halt  input  1  decode saw HALT; stop fetching permanently.
REQ-013 SHALL have ports: ifid_valid  output  1, ifid_instr  output  32, ifid_pc  output  32, ifid_npc  output  32 (IF/ID latch contents).

Function
REQ-014 SHALL implement states FETCH, REDIR_PEND, HALTED; reset state FETCH.
REQ-015 SHALL drive imemaddr = PC register combinationally; imemaddr SHALL not change while ihit=0 (no mid-miss address change).
REQ-016 SHALL drive imemREN=1 in FETCH and REDIR_PEND, 0 in HALTED.
REQ-017 FETCH, ihit=1, stall=0, no redirect/flush: SHALL load ifid_instr=imemload, ifid_pc=PC, ifid_npc=PC+4, ifid_valid=1; PC<=PC+4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-018 ihit=1 with stall=1: SHALL hold PC and all IF/ID outputs; imemREN stays 1.
REQ-019 ihit=0: SHALL hold PC; IF/ID held unless flush/redirect.
REQ-020 redirect_en=1 with ihit=1 (FETCH): PC<=redirect_pc, fetched word discarded, ifid_valid<=0; state stays FETCH.
REQ-021 redirect_en=1 with ihit=0 (FETCH): SHALL capture redirect_pc into pending register, ifid_valid<=0, go REDIR_PEND; PC unchanged.
REQ-022 REDIR_PEND: on ihit=1 SHALL discard word, PC<=pending target, ifid_valid<=0, go FETCH; a further redirect_en overwrites pending target.
REQ-023 Redirect SHALL take priority over stall; redirect_pc[1:0] SHALL be forced to 2'b00.
REQ-024 flush=1 SHALL force ifid_valid<=0 next edge, overriding any load in REQ-017; PC advances per REQ-017 if otherwise allowed.
REQ-025 halt=1 in any state SHALL go HALTED, ifid_valid<=0, PC frozen; halt beats redirect/flush/stall; HALTED exits only via nRST.
REQ-026 ifid_instr/pc/npc SHALL only change on a valid load (REQ-017); squashes clear ifid_valid only.

Reset
REQ-027 nRST=0 SHALL asynchronously set PC=PC_INIT, state=FETCH, pending target=0, ifid_valid=0, ifid_instr/pc/npc=0.
REQ-028 Reset mid-miss or in REDIR_PEND SHALL drop the pending redirect; first post-reset fetch at PC_INIT.

Structure
REQ-029 SHALL place the state enum (fetch_state_t) and IF/ID record typedef (ifid_t: valid, instr, pc, npc) in cpu_types_pkg; word_t used for 32-bit fields.
REQ-030 SHALL be a single module; PC/state register block plus next-state combinational block; no sub-module.

Verification
REQ-031 Reset, ihit=1 constant, imemload=32'h2001_0005: imemaddr 0,4,8 on successive cycles; ifid_pc=0, ifid_npc=4 after first edge.
REQ-032 PC=32'h40, ihit=0 three cycles then 1 with stall=1 two cycles: imemaddr stays 32'h40, IF/ID unchanged until stall drops, then ifid_pc=32'h40.
REQ-033 PC=32'h10, ihit=0, redirect_en=1 redirect_pc=32'h103 one cycle, ihit=1 two cycles later: state REDIR_PEND, addr 32'h10 held, then PC=32'h100, ifid_valid=0.
REQ-034 ihit=1, stall=1, redirect_en=1 redirect_pc=32'h200 same cycle: PC=32'h200 next edge, ifid_valid=0.
REQ-035 halt=1 with redirect_en=1: imemREN=0 next cycle, PC frozen, ifid_valid=0; stays HALTED until nRST pulse, then imemaddr=PC_INIT.
REQ-036 PC=32'hFFFF_FFFC, ihit=1: ifid_npc=0, next imemaddr=0; nRST asserted mid-miss clears all outputs asynchronously.
